// File: rtl/uk101_pkg.sv
// Shared types and constants for the UK101 save-to-file capture path.
package uk101_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        UPLOAD  = 2'd2
    } save_state_t;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_EOF = 8'h1A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;

    // NUL bytes are line-end padding from the UK101 and carry no file content.
    function automatic logic byte_kept(input logic [7:0] data, input logic strip_nul);
        return !(strip_nul && (data == ASCII_NUL));
    endfunction

endpackage

// File: rtl/uk101_save_capture_if.sv
// hps_io ioctl upload handshake between the HPS side and the capture buffer.
interface uk101_save_capture_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [15:0] ioctl_addr;
    logic [7:0]  ioctl_din;

    modport master (output ioctl_upload, output ioctl_rd, output ioctl_addr, input ioctl_din);
    modport slave  (input ioctl_upload, input ioctl_rd, input ioctl_addr, output ioctl_din);
endinterface

// File: rtl/uk101_capture_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module uk101_capture_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:(1 << ADDR_W) - 1];
    logic [7:0] rdata_r;

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_r <= mem[raddr];
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/uk101_save_capture.sv
// Captures bytes written to the UK101 ACIA TX register and serves them back
// to the HPS over the ioctl upload handshake as a text file.
module uk101_save_capture
    import uk101_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter bit         STRIP_NUL = 1'b1,
    parameter logic [7:0] EOF_BYTE  = ASCII_EOF
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    capture_en,
    input  logic                    clear,
    input  logic                    tx_strobe,
    input  logic [7:0]              tx_data,
    uk101_save_capture_if.slave     ioctl,
    output logic                    upload_req,
    output logic [ADDR_W:0]         capture_len,
    output logic                    overflow,
    output logic                    busy
);

    localparam int CMP_W = ((ADDR_W + 1) > 16) ? (ADDR_W + 1) : 16;

    save_state_t     state_r;
    save_state_t     state_s;
    logic            upload_q_r;
    logic            upload_rise_s;
    logic [ADDR_W:0] len_r;
    logic            overflow_r;
    logic            upload_req_r;
    logic            busy_r;
    logic [7:0]      din_r;
    logic            rd_pend_r;
    logic            eof_sel_r;
    logic            clear_s;
    logic            store_s;
    logic            we_s;
    logic            drop_s;
    logic [7:0]      ram_rdata_s;
    logic [CMP_W-1:0] addr_ext_s;
    logic [CMP_W-1:0] len_ext_s;

    assign upload_rise_s = ioctl.ioctl_upload & ~upload_q_r;
    assign addr_ext_s    = CMP_W'(ioctl.ioctl_addr);
    assign len_ext_s     = CMP_W'(len_r);

    // Next-state logic; an upload start pre-empts every other state.
    always_comb begin
        state_s = state_r;
        if (upload_rise_s) begin
            state_s = UPLOAD;
        end else begin
            case (state_r)
                IDLE: begin
                    if (capture_en) state_s = CAPTURE;
                    else            state_s = IDLE;
                end
                CAPTURE: begin
                    if (!capture_en) state_s = IDLE;
                    else             state_s = CAPTURE;
                end
                UPLOAD: begin
                    if (!ioctl.ioctl_upload) state_s = IDLE;
                    else                     state_s = UPLOAD;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // Store decision: clear beats a same-cycle strobe, and the buffer never wraps.
    always_comb begin
        clear_s = 1'b0;
        store_s = 1'b0;
        if (state_r != UPLOAD) begin
            clear_s = clear;
        end else begin
            clear_s = 1'b0;
        end
        if ((state_r == CAPTURE) && tx_strobe && !clear_s) begin
            store_s = byte_kept(tx_data, STRIP_NUL);
        end else begin
            store_s = 1'b0;
        end
        we_s   = store_s && !len_r[ADDR_W];
        drop_s = store_s &&  len_r[ADDR_W];
    end

    // State register plus the registered status outputs derived from it.
    // upload_q_r resets high so an upload still asserted across reset is not
    // mistaken for a fresh start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            upload_q_r   <= 1'b1;
            busy_r       <= 1'b0;
            upload_req_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            upload_q_r   <= ioctl.ioctl_upload;
            busy_r       <= (state_s == UPLOAD);
            upload_req_r <= (state_r == CAPTURE) && !capture_en && !upload_rise_s &&
                            (len_r != {(ADDR_W + 1){1'b0}});
        end
    end

    // Length counter and sticky overflow flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            len_r      <= {(ADDR_W + 1){1'b0}};
            overflow_r <= 1'b0;
        end else if (clear_s) begin
            len_r      <= {(ADDR_W + 1){1'b0}};
            overflow_r <= 1'b0;
        end else if (we_s) begin
            len_r      <= len_r + {{ADDR_W{1'b0}}, 1'b1};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Two-stage upload read: RAM access and EOF decision, then the output mux.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rd_pend_r <= 1'b0;
            eof_sel_r <= 1'b0;
            din_r     <= 8'h00;
        end else begin
            rd_pend_r <= (state_r == UPLOAD) && ioctl.ioctl_rd;
            eof_sel_r <= (addr_ext_s >= len_ext_s);
            if (rd_pend_r) begin
                din_r <= eof_sel_r ? EOF_BYTE : ram_rdata_s;
            end
        end
    end

    uk101_capture_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_sys),
        .we    (we_s),
        .waddr (len_r[ADDR_W-1:0]),
        .wdata (tx_data),
        .raddr (ioctl.ioctl_addr[ADDR_W-1:0]),
        .rdata (ram_rdata_s)
    );

    assign ioctl.ioctl_din = din_r;
    assign upload_req      = upload_req_r;
    assign capture_len     = len_r;
    assign overflow        = overflow_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_uk101_save_capture.sv
// Directed bench for uk101_save_capture: a default-size instance and a
// 16-byte instance for the full-buffer case.
module tb_uk101_save_capture;

    logic        clk_sys = 1'b0;
    logic        reset;

    logic        capture_en, clear, tx_strobe;
    logic [7:0]  tx_data;
    logic        upload_req, overflow, busy;
    logic [14:0] capture_len;

    logic        s_capture_en, s_clear, s_tx_strobe;
    logic [7:0]  s_tx_data;
    logic        s_upload_req, s_overflow, s_busy;
    logic [4:0]  s_capture_len;

    int checks = 0;
    int errors = 0;

    uk101_save_capture_if m_if ();
    uk101_save_capture_if s_if ();

    uk101_save_capture u_dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .capture_en  (capture_en),
        .clear       (clear),
        .tx_strobe   (tx_strobe),
        .tx_data     (tx_data),
        .ioctl       (m_if),
        .upload_req  (upload_req),
        .capture_len (capture_len),
        .overflow    (overflow),
        .busy        (busy)
    );

    uk101_save_capture #(.ADDR_W(4)) u_small (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .capture_en  (s_capture_en),
        .clear       (s_clear),
        .tx_strobe   (s_tx_strobe),
        .tx_data     (s_tx_data),
        .ioctl       (s_if),
        .upload_req  (s_upload_req),
        .capture_len (s_capture_len),
        .overflow    (s_overflow),
        .busy        (s_busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic strobe(input int sel, input logic [7:0] b);
        @(negedge clk_sys);
        if (sel == 0) begin
            tx_strobe = 1'b1;
            tx_data   = b;
        end else begin
            s_tx_strobe = 1'b1;
            s_tx_data   = b;
        end
        @(negedge clk_sys);
        tx_strobe   = 1'b0;
        s_tx_strobe = 1'b0;
    endtask

    task automatic pulse_clear(input int sel);
        @(negedge clk_sys);
        if (sel == 0) clear = 1'b1;
        else          s_clear = 1'b1;
        @(negedge clk_sys);
        clear   = 1'b0;
        s_clear = 1'b0;
    endtask

    // Read request, then din must hold its old value after edge 1 and carry
    // the new value after edge 2.
    task automatic rd(input int sel, input logic [15:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] prev;
        @(negedge clk_sys);
        prev = (sel == 0) ? m_if.ioctl_din : s_if.ioctl_din;
        if (sel == 0) begin
            m_if.ioctl_rd = 1'b1; m_if.ioctl_addr = a;
        end else begin
            s_if.ioctl_rd = 1'b1; s_if.ioctl_addr = a;
        end
        @(negedge clk_sys);
        m_if.ioctl_rd = 1'b0;
        s_if.ioctl_rd = 1'b0;
        check({tag, "_hold"}, (sel == 0) ? m_if.ioctl_din : s_if.ioctl_din, prev);
        @(negedge clk_sys);
        check(tag, (sel == 0) ? m_if.ioctl_din : s_if.ioctl_din, exp);
    endtask

    initial begin
        string      text;
        logic [7:0] exp_b [10];
        exp_b = '{8'h31, 8'h30, 8'h20, 8'h50, 8'h52, 8'h49, 8'h4E, 8'h54, 8'h0D, 8'h0A};
        text  = "10 PRINT";

        reset = 1'b1;
        capture_en = 1'b0; clear = 1'b0; tx_strobe = 1'b0; tx_data = 8'h00;
        s_capture_en = 1'b0; s_clear = 1'b0; s_tx_strobe = 1'b0; s_tx_data = 8'h00;
        m_if.ioctl_upload = 1'b0; m_if.ioctl_rd = 1'b0; m_if.ioctl_addr = 16'h0000;
        s_if.ioctl_upload = 1'b0; s_if.ioctl_rd = 1'b0; s_if.ioctl_addr = 16'h0000;

        #1;
        check("rst_len", capture_len, 0);
        check("rst_ovf", overflow, 0);
        check("rst_din", m_if.ioctl_din, 0);
        check("rst_req", upload_req, 0);
        check("rst_busy", busy, 0);
        @(negedge clk_sys);
        reset = 1'b0;
        tick(1);

        // Capture with NUL stripping
        capture_en = 1'b1;
        for (int i = 0; i < text.len(); i++) strobe(0, text[i]);
        strobe(0, 8'h0D);
        strobe(0, 8'h00);
        strobe(0, 8'h00);
        strobe(0, 8'h0A);
        check("cap_len", capture_len, 10);
        check("cap_req_lo", upload_req, 0);
        @(negedge clk_sys);
        capture_en = 1'b0;
        @(negedge clk_sys);
        check("cap_req_pulse", upload_req, 1);
        @(negedge clk_sys);
        check("cap_req_end", upload_req, 0);
        check("cap_len_kept", capture_len, 10);

        // Upload read-back
        m_if.ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("up_busy", busy, 1);
        for (int i = 0; i < 10; i++) rd(0, 16'(i), exp_b[i], "rd_data");
        rd(0, 16'd10, 8'h1A, "rd_eof_len");
        rd(0, 16'hFFFF, 8'h1A, "rd_eof_ffff");
        rd(0, 16'h4001, 8'h1A, "rd_eof_hibit");

        // Ignored strobe and clear during upload
        strobe(0, 8'h77);
        check("up_strobe_len", capture_len, 10);
        check("up_strobe_ovf", overflow, 0);
        pulse_clear(0);
        check("up_clear_len", capture_len, 10);

        // Ignored strobe in IDLE
        m_if.ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("idle_busy", busy, 0);
        strobe(0, 8'h78);
        check("idle_len", capture_len, 10);
        check("idle_ovf", overflow, 0);
        check("idle_req", upload_req, 0);

        // capture_en raised in UPLOAD only takes effect after upload ends
        m_if.ioctl_upload = 1'b1;
        tick(1);
        capture_en = 1'b1;
        strobe(0, 8'h79);
        check("up_en_len", capture_len, 10);
        check("up_en_busy", busy, 1);
        m_if.ioctl_upload = 1'b0;
        tick(1);

        // Clear collision
        pulse_clear(0);
        check("clr_len", capture_len, 0);
        for (int i = 0; i < 5; i++) strobe(0, 8'(8'h31 + i));
        check("clr_pre_len", capture_len, 5);
        @(negedge clk_sys);
        clear = 1'b1; tx_strobe = 1'b1; tx_data = 8'h55;
        @(negedge clk_sys);
        clear = 1'b0; tx_strobe = 1'b0;
        check("coll_len", capture_len, 0);
        check("coll_ovf", overflow, 0);
        strobe(0, 8'h56);
        check("coll_next_len", capture_len, 1);
        @(negedge clk_sys);
        capture_en = 1'b0;
        @(negedge clk_sys);
        check("coll_req", upload_req, 1);
        m_if.ioctl_upload = 1'b1;
        tick(1);
        rd(0, 16'd0, 8'h56, "coll_rd0");
        rd(0, 16'd1, 8'h1A, "coll_rd1");

        // Async reset between read request and data valid
        @(negedge clk_sys);
        m_if.ioctl_rd = 1'b1; m_if.ioctl_addr = 16'd0;
        @(posedge clk_sys);
        #2 reset = 1'b1;
        #1;
        check("ar_din", m_if.ioctl_din, 0);
        check("ar_busy", busy, 0);
        check("ar_len", capture_len, 0);
        check("ar_req", upload_req, 0);
        @(negedge clk_sys);
        m_if.ioctl_rd = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        tick(2);
        check("ar_idle_busy", busy, 0);
        rd(0, 16'd0, 8'h00, "ar_rd_after");
        m_if.ioctl_upload = 1'b0;
        tick(1);

        // Full buffer on the 16-byte instance
        s_capture_en = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) strobe(1, 8'(8'h41 + i));
        check("full_len16", s_capture_len, 16);
        check("full_ovf_pre", s_overflow, 0);
        strobe(1, 8'h51);
        check("full_len", s_capture_len, 16);
        check("full_ovf", s_overflow, 1);
        @(negedge clk_sys);
        s_capture_en = 1'b0;
        tick(2);
        s_if.ioctl_upload = 1'b1;
        tick(1);
        rd(1, 16'd15, 8'h50, "full_rd15");
        rd(1, 16'd0, 8'h41, "full_rd0");
        rd(1, 16'd16, 8'h1A, "full_rd16");
        s_if.ioctl_upload = 1'b0;
        tick(1);
        pulse_clear(1);
        check("full_clr_len", s_capture_len, 0);
        check("full_clr_ovf", s_overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
